// File: rtl/data_selector.sv
`default_nettype none
// ============================================================================
// Module   : data_selector
// Purpose  : One-hot select multiplexer with a lowest-index-wins fallback for
//            multi-hot selects, plus registered copies and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module data_selector #(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_WIDTH-1:0]  sel_in,
    input  logic [DATA_WIDTH-1:0] data_in [SEL_WIDTH],
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  multi_hot,
    output logic [DATA_WIDTH-1:0] data_out_q,
    output logic                  data_out_valid_q,
    output logic                  multi_hot_sticky
);

    localparam logic [SEL_WIDTH-1:0] c_one = SEL_WIDTH'(1);

    logic [SEL_WIDTH-1:0]  w_lowest;
    logic [DATA_WIDTH-1:0] w_masked [SEL_WIDTH];
    logic [DATA_WIDTH-1:0] w_data;

    // Two's-complement trick isolates the lowest set bit, so the AND-OR mux
    // below always sees a true one-hot (or zero) select.
    assign w_lowest = sel_in & (~sel_in + c_one);

    generate
        for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_mask
            assign w_masked[gi] = data_in[gi] & {DATA_WIDTH{w_lowest[gi]}};
        end
    endgenerate

    always_comb begin
        w_data = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            w_data = w_data | w_masked[i];
        end
    end

    assign data_out       = w_data;
    assign data_out_valid = |sel_in;
    // Any bit surviving after the lowest one is removed means multi-hot.
    assign multi_hot      = |(sel_in & ~w_lowest);

    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;
    logic                  r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_data_q  <= w_data;
            r_valid_q <= data_out_valid;
            r_sticky  <= r_sticky | multi_hot;
        end
    end

    assign data_out_q       = r_data_q;
    assign data_out_valid_q = r_valid_q;
    assign multi_hot_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_data_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_selector
// Purpose  : Self-checking bench for data_selector against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_selector;

    localparam int SW = 4;
    localparam int DW = 2;

    typedef logic [DW-1:0] data_arr_t [SW];

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sel_in;
    data_arr_t     data_in;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          multi_hot;
    logic [DW-1:0] data_out_q;
    logic          data_out_valid_q;
    logic          multi_hot_sticky;

    int n_vec = 0;
    int n_err = 0;

    // registered-path expectations
    logic [DW-1:0] e_q;
    logic          e_vq;
    logic          e_sticky;

    always #5 clk = ~clk;

    data_selector #(.SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .sel_in           (sel_in),
        .data_in          (data_in),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .multi_hot        (multi_hot),
        .data_out_q       (data_out_q),
        .data_out_valid_q (data_out_valid_q),
        .multi_hot_sticky (multi_hot_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: pick the lowest-indexed selected entry; count bits for multi-hot.
    task automatic model(input logic [SW-1:0] s, input data_arr_t d,
                         output logic [DW-1:0] md, output logic mv, output logic mm);
        md = '0;
        for (int i = SW - 1; i >= 0; i--)
            if (s[i]) md = d[i];
        mv = (s != 0);
        mm = ($countones(s) > 1);
    endtask

    task automatic check_comb(input string tag);
        logic [DW-1:0] md;
        logic mv, mm;
        model(sel_in, data_in, md, mv, mm);
        check({tag, ".data_out"},  32'(data_out), 32'(md));
        check({tag, ".valid"},     32'(data_out_valid), 32'(mv));
        check({tag, ".multi_hot"}, 32'(multi_hot), 32'(mm));
    endtask

    // Advance one clock, update the registered model, check registered outputs.
    task automatic tick(input string tag);
        logic [DW-1:0] md;
        logic mv, mm;
        model(sel_in, data_in, md, mv, mm);
        @(posedge clk);
        if (rst) begin
            e_q = '0; e_vq = 1'b0; e_sticky = 1'b0;
        end else begin
            e_q = md; e_vq = mv; e_sticky = e_sticky | mm;
        end
        #1;
        check({tag, ".data_out_q"}, 32'(data_out_q), 32'(e_q));
        check({tag, ".valid_q"},    32'(data_out_valid_q), 32'(e_vq));
        check({tag, ".sticky"},     32'(multi_hot_sticky), 32'(e_sticky));
    endtask

    task automatic apply(input logic [SW-1:0] s, input string tag);
        sel_in = s;
        #1;
        check_comb(tag);
    endtask

    initial begin
        logic [SW-1:0] s;
        rst    = 1'b1;
        sel_in = '0;
        for (int i = 0; i < SW; i++) data_in[i] = DW'(i);
        e_q = '0; e_vq = 1'b0; e_sticky = 1'b0;

        tick("reset");
        rst = 1'b0;
        #1;

        apply('0, "sel_zero");
        check("sel_zero.lit_data", 32'(data_out), 32'd0);
        tick("idle");

        for (int i = 0; i < SW; i++) begin
            apply(SW'(1) << i, "onehot");
            check("onehot.lit_data", 32'(data_out), 32'(i));
        end
        tick("onehot_reg");

        apply(4'b1010, "multi");
        check("multi.lit_data", 32'(data_out), 32'd1);
        check("multi.lit_mh", 32'(multi_hot), 32'd1);
        tick("multi_reg");
        check("sticky_set", 32'(multi_hot_sticky), 32'd1);
        apply(4'b0001, "back_onehot");
        tick("sticky_hold");
        check("sticky_hold.lit", 32'(multi_hot_sticky), 32'd1);

        // Before the edge the registered output still shows the previous value.
        apply(4'b0100, "reg_path");
        check("reg_path.before", 32'(data_out_q), 32'd0);
        tick("reg_path");
        check("reg_path.lit_q", 32'(data_out_q), 32'd2);

        apply(4'b1000, "pre_rst");
        rst = 1'b1;
        #1;
        check_comb("in_rst");
        check("in_rst.lit_data", 32'(data_out), 32'd3);
        tick("rst_edge");
        check("rst_edge.lit_sticky", 32'(multi_hot_sticky), 32'd0);
        check_comb("in_rst_after");
        rst = 1'b0;
        tick("rst_release");

        // All-ones data across every one-hot select.
        for (int i = 0; i < SW; i++) data_in[i] = '1;
        for (int i = 0; i < SW; i++) begin
            apply(SW'(1) << i, "all_ones");
            tick("all_ones_reg");
        end

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < SW; i++) data_in[i] = DW'($urandom);
            if (n % 2 == 0) s = SW'(1) << $urandom_range(SW - 1, 0);
            else            s = SW'($urandom);
            if (n == 150) rst = 1'b1;
            if (n == 152) rst = 1'b0;
            apply(s, "rand");
            tick("rand_reg");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_selector.md
Name:
data_selector

Overview:
- One-hot-select data multiplexer: `sel_in` bit i selects `data_in[i]` onto `data_out`. `data_out_valid` asserts when a selection is present.
- Select-to-output path is combinational, zero latency. A registered copy is also provided for timing-critical consumers.
- Generic building block under basic/. Used wherever a one-hot grant or hit vector picks one of N entries, e.g. issue-queue grant or CAM hit.

Parameters:
- SEL_WIDTH, 4, number of inputs; also the width of the one-hot select; >=1.
- DATA_WIDTH, 2, width of each data entry and of the output; >=1.

Ports:
- clk  input  1  clock for the registered outputs.
- rst  input  1  synchronous active-high reset.
- sel_in  input  SEL_WIDTH  one-hot select vector; bit i selects entry i.
- data_in  input  SEL_WIDTH x DATA_WIDTH  unpacked array, indices 0..SEL_WIDTH-1.
- data_out  output  DATA_WIDTH  selected data, combinational.
- data_out_valid  output  1  sel_in is nonzero, combinational.
- multi_hot  output  1  more than one sel_in bit is set, combinational.
- data_out_q  output  DATA_WIDTH  data_out registered on clk.
- data_out_valid_q  output  1  data_out_valid registered on clk.
- multi_hot_sticky  output  1  sticky error flag; set on any clock edge where multi_hot=1; cleared only by rst.

Behaviour:
- Combinational path, with no clock or reset dependency:
  - sel_in == 0 -> data_out_valid=0, data_out=0, multi_hot=0.
  - Exactly one bit i set -> data_out_valid=1, data_out=data_in[i], multi_hot=0.
  - Several bits set -> data_out_valid=1, multi_hot=1, data_out=data_in[lowest set index] (lowest index has priority).
  - Outputs follow any change of sel_in or data_in within the same delta/cycle; no latches.
- Widths: each data_in entry is DATA_WIDTH bits; no extension or truncation. Any value assigned by the driver is truncated to DATA_WIDTH by the driver, not by this block.
- Registered path, on posedge clk:
  - rst=1 -> data_out_q=0, data_out_valid_q=0, multi_hot_sticky=0.
  - Otherwise data_out_q <= data_out and data_out_valid_q <= data_out_valid. Latency is exactly 1 cycle.
  - multi_hot_sticky <= multi_hot_sticky | multi_hot.
- Reset does not affect the combinational outputs.
- Reset mid-operation: registered outputs read 0 on the cycle after the rst edge. They then resume tracking the combinational values on the first edge with rst=0.
- SEL_WIDTH=1: data_out = sel_in[0] ? data_in[0] : 0; multi_hot is constant 0.
- The implementation must be synthesizable and parameter-generic, using loops or generate. No hardcoded case lists.

Test Plan:
- data_in[i]=i for i=0..3, sel_in=0 -> data_out_valid=0, data_out=0, multi_hot=0.
- Same data, sel_in=1<<i for i=0..3 -> data_out_valid=1, data_out=i, multi_hot=0 in every step, with zero settling cycles.
- sel_in=4'b1010 with data_in={0,1,2,3} -> data_out=1, data_out_valid=1, multi_hot=1. On the next posedge multi_hot_sticky=1, and it stays 1 after sel_in returns to 4'b0001.
- Registered path: sel_in=4'b0100 (other data as above) -> data_out_q=2 and data_out_valid_q=1 one posedge later. Before that edge, data_out_q holds its prior value.
- Assert rst for one edge while sel_in=4'b1000 -> data_out_q=0, data_out_valid_q=0, multi_hot_sticky=0 after the edge. data_out=3 and data_out_valid=1 remain throughout the reset.
- Random data_in values with every one-hot sel_in -> data_out equals the selected entry bit-exactly. Cover all-ones data to confirm there is no truncation.
